// File: rtl/switch_toggle_seq.sv
`timescale 1ns/1ps
// Toggle-time sequencer: replays a loaded interval table and inverts sw_ctrl at each expiry.
// Latency: start applies init_val at the same edge; toggle k lands sum(max(Ti,1), i<=k) cycles later.
// Backpressure: ld_ready drops while replaying or when the table is full; SWITCH_SEQ_REPEAT_EN loops the table.
module switch_toggle_seq #(
    parameter int DEPTH = 8,
    parameter int CW    = 24,
    parameter bit INIT  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [CW-1:0]              ld_data,
    input  logic                       start,
    input  logic                       init_val,
    output logic                       sw_ctrl,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic                       err_ovf
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] CNT_FULL = (IW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   tbl [DEPTH];
    logic [IW:0]     count;
    logic [CW-1:0]   timer;
    logic [IW-1:0]   idx_nxt;
    logic            wr_en, ovf_set, go, expire, last;

    // A zero interval still costs one cycle so every entry produces a distinct toggle.
    function automatic logic [CW-1:0] ivl(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    assign ld_ready = (state_q == IDLE) && (count != CNT_FULL);
    assign busy     = (state_q == RUN);
    assign idx_nxt  = idx + IW'(1);

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        ovf_set = 1'b0;
        go      = 1'b0;
        expire  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr_en   = ld_valid && ld_ready;
                ovf_set = ld_valid && !ld_ready;
                go      = start && !ld_valid;
                if (go && count != '0) state_d = RUN;
            end
            RUN: begin
                expire = (timer <= CW'(1));
                last   = expire && (({1'b0, idx} + (IW+1)'(1)) == count);
`ifndef SWITCH_SEQ_REPEAT_EN
                if (last) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst && !clear) tbl[count[IW-1:0]] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sw_ctrl <= INIT;
            done    <= 1'b0;
            idx     <= '0;
            err_ovf <= 1'b0;
            count   <= '0;
            timer   <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            done    <= 1'b0;
            idx     <= '0;
            err_ovf <= 1'b0;
            count   <= '0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            if (wr_en)   count   <= count + (IW+1)'(1);
            if (ovf_set) err_ovf <= 1'b1;
            if (go) begin
                sw_ctrl <= init_val;
                idx     <= '0;
                timer   <= ivl(tbl[0]);
                if (count == '0) done <= 1'b1;
            end
            if (expire) begin
                sw_ctrl <= ~sw_ctrl;
                if (!last) begin
                    idx   <= idx_nxt;
                    timer <= ivl(tbl[idx_nxt]);
                end else begin
                    done <= 1'b1;
`ifdef SWITCH_SEQ_REPEAT_EN
                    idx   <= '0;
                    timer <= ivl(tbl[0]);
`endif
                end
            end else if (state_q == RUN) begin
                timer <= timer - CW'(1);
            end
        end
    end
endmodule
